// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - decode-to-execute pipeline register with ARM condition unit
//
// Purpose:
//   Holds the decoder control word and condition field for the instruction in
//   the E stage. Evaluates the condition against the architectural NZCV
//   register owned here, suppresses the side effects of failed instructions,
//   and updates NZCV from the ALU flags of passing flag-setting instructions.
//
// Optional feature:
//   COND_ANNUL_CNT_EN - when defined, AnnulCount counts annulled instructions
//   that would otherwise have had a side effect. When undefined it is tied to 0.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   StallE, FlushE        hold E register / load bubble (flush wins)
//   CondD .. WA3D         decoder condition field and controls
//   ALUFlags              {N,Z,C,V} from the E-stage ALU (combinational)
//   ALUControlE .. WA3E   registered, ungated controls
//   CondExE               condition passed for the instruction in E
//   PCSrcE .. BranchTakenE  condition-gated controls
//   Flags                 architectural {N,Z,C,V}
//   AnnulCount            annulled-instruction counter

module cond_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [3:0]  CondD,
  input  logic        PCSD,
  input  logic        RegWD,
  input  logic        MemWD,
  input  logic        MemtoRegD,
  input  logic        ALUSrcD,
  input  logic        BranchD,
  input  logic        NoWriteD,
  input  logic        IgRnD,
  input  logic [1:0]  FlagWD,
  input  logic [3:0]  ALUControlD,
  input  logic [3:0]  WA3D,
  input  logic [3:0]  ALUFlags,
  output logic [3:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic        MemtoRegE,
  output logic        IgRnE,
  output logic [3:0]  WA3E,
  output logic        CondExE,
  output logic        PCSrcE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchTakenE,
  output logic [3:0]  Flags,
  output logic [31:0] AnnulCount
);

  // E register fields
  logic [3:0] cond_q,   cond_d;
  logic       pcs_q,    pcs_d;
  logic       regw_q,   regw_d;
  logic       memw_q,   memw_d;
  logic       m2r_q,    m2r_d;
  logic       alusrc_q, alusrc_d;
  logic       branch_q, branch_d;
  logic       nowr_q,   nowr_d;
  logic       ignr_q,   ignr_d;
  logic [1:0] flagw_q,  flagw_d;
  logic [3:0] aluctl_q, aluctl_d;
  logic [3:0] wa3_q,    wa3_d;

  logic [3:0] flags_q,  flags_d;

  logic n_f, z_f, c_f, v_f;
  logic cond_ex;
  logic has_effect;

  // Flush takes priority over stall so a bubble can be inserted into a held stage.
  always_comb begin
    cond_d   = CondD;
    pcs_d    = PCSD;
    regw_d   = RegWD;
    memw_d   = MemWD;
    m2r_d    = MemtoRegD;
    alusrc_d = ALUSrcD;
    branch_d = BranchD;
    nowr_d   = NoWriteD;
    ignr_d   = IgRnD;
    flagw_d  = FlagWD;
    aluctl_d = ALUControlD;
    wa3_d    = WA3D;
    if (FlushE) begin
      cond_d   = 4'h0;
      pcs_d    = 1'b0;
      regw_d   = 1'b0;
      memw_d   = 1'b0;
      m2r_d    = 1'b0;
      alusrc_d = 1'b0;
      branch_d = 1'b0;
      nowr_d   = 1'b0;
      ignr_d   = 1'b0;
      flagw_d  = 2'b00;
      aluctl_d = 4'h0;
      wa3_d    = 4'h0;
    end else if (StallE) begin
      cond_d   = cond_q;
      pcs_d    = pcs_q;
      regw_d   = regw_q;
      memw_d   = memw_q;
      m2r_d    = m2r_q;
      alusrc_d = alusrc_q;
      branch_d = branch_q;
      nowr_d   = nowr_q;
      ignr_d   = ignr_q;
      flagw_d  = flagw_q;
      aluctl_d = aluctl_q;
      wa3_d    = wa3_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_q   <= 4'h0;
      pcs_q    <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      m2r_q    <= 1'b0;
      alusrc_q <= 1'b0;
      branch_q <= 1'b0;
      nowr_q   <= 1'b0;
      ignr_q   <= 1'b0;
      flagw_q  <= 2'b00;
      aluctl_q <= 4'h0;
      wa3_q    <= 4'h0;
    end else begin
      cond_q   <= cond_d;
      pcs_q    <= pcs_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      m2r_q    <= m2r_d;
      alusrc_q <= alusrc_d;
      branch_q <= branch_d;
      nowr_q   <= nowr_d;
      ignr_q   <= ignr_d;
      flagw_q  <= flagw_d;
      aluctl_q <= aluctl_d;
      wa3_q    <= wa3_d;
    end
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_q)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // N,Z and C,V are written independently so logical ops can leave C,V intact.
  // A stalled instruction holds NZCV so it cannot write the flags twice.
  always_comb begin
    flags_d = flags_q;
    if (!StallE) begin
      if (flagw_q[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
      if (flagw_q[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'h0;
    else        flags_q <= flags_d;
  end

  assign has_effect = regw_q | memw_q | pcs_q | branch_q | (flagw_q != 2'b00);

`ifdef COND_ANNUL_CNT_EN
  logic [31:0] annul_q, annul_d;

  always_comb begin
    annul_d = annul_q;
    if (!StallE && !cond_ex && has_effect) annul_d = annul_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) annul_q <= 32'h0;
    else        annul_q <= annul_d;
  end

  assign AnnulCount = annul_q;
`else
  logic unused_effect;
  assign unused_effect = has_effect;
  assign AnnulCount    = 32'h0;
`endif

  assign ALUControlE  = aluctl_q;
  assign ALUSrcE      = alusrc_q;
  assign MemtoRegE    = m2r_q;
  assign IgRnE        = ignr_q;
  assign WA3E         = wa3_q;
  assign CondExE      = cond_ex;
  assign PCSrcE       = pcs_q & cond_ex;
  assign RegWriteE    = regw_q & cond_ex & ~nowr_q;
  assign MemWriteE    = memw_q & cond_ex;
  assign BranchTakenE = branch_q & cond_ex;
  assign Flags        = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - directed self-checking bench for cond_exec_stage

module tb_cond_exec_stage;

  logic        clk;
  logic        reset;
  logic        StallE, FlushE;
  logic [3:0]  CondD;
  logic        PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD, IgRnD;
  logic [1:0]  FlagWD;
  logic [3:0]  ALUControlD, WA3D, ALUFlags;
  logic [3:0]  ALUControlE, WA3E, Flags;
  logic        ALUSrcE, MemtoRegE, IgRnE, CondExE;
  logic        PCSrcE, RegWriteE, MemWriteE, BranchTakenE;
  logic [31:0] AnnulCount;

  int checks_total;
  int checks_passed;
  logic [31:0] exp_annul;

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .CondD(CondD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
    .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .NoWriteD(NoWriteD), .IgRnD(IgRnD), .FlagWD(FlagWD),
    .ALUControlD(ALUControlD), .WA3D(WA3D), .ALUFlags(ALUFlags),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .IgRnE(IgRnE), .WA3E(WA3E), .CondExE(CondExE), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchTakenE(BranchTakenE),
    .Flags(Flags), .AnnulCount(AnnulCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Condition truth table written as pairs: odd codes invert the even base.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic drive_d(input logic [3:0] cond, input logic pcs, input logic regw,
                         input logic memw, input logic branch, input logic nowr,
                         input logic [1:0] fw, input logic [3:0] aluctl, input logic [3:0] wa3);
    CondD = cond; PCSD = pcs; RegWD = regw; MemWD = memw; BranchD = branch;
    NoWriteD = nowr; FlagWD = fw; ALUControlD = aluctl; WA3D = wa3;
    MemtoRegD = memw; ALUSrcD = regw; IgRnD = nowr;
  endtask

  task automatic idle_d();
    drive_d(4'h0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total = 0; checks_passed = 0; exp_annul = 0;
    reset = 1'b0; StallE = 0; FlushE = 0; ALUFlags = 4'h0;
    idle_d();
    #12;
    check("rst_flags", {28'h0, Flags}, 32'h0);
    check("rst_condex", {31'h0, CondExE}, 32'h0);
    check("rst_regw", {31'h0, RegWriteE}, 32'h0);
    check("rst_annul", AnnulCount, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // CMP: AL, sets all flags, NoWrite suppresses register write
    drive_d(4'hE, 0, 1, 0, 0, 1, 2'b11, 4'h2, 4'h5);
    step();
    check("cmp_regw", {31'h0, RegWriteE}, 32'h0);
    check("cmp_condex", {31'h0, CondExE}, 32'h1);
    check("cmp_aluctl", {28'h0, ALUControlE}, 32'h2);
    check("cmp_wa3", {28'h0, WA3E}, 32'h5);
    check("cmp_alusrc", {31'h0, ALUSrcE}, 32'h1);
    ALUFlags = 4'b0100;
    drive_d(4'h0, 1, 0, 0, 1, 0, 2'b00, 4'h0, 4'h0);   // BEQ
    step();
    check("cmp_flags", {28'h0, Flags}, 32'h4);
    check("beq_taken", {31'h0, BranchTakenE}, 32'h1);
    check("beq_pcsrc", {31'h0, PCSrcE}, 32'h1);

    // Clear flags, then ADDEQ fails with Z=0
    drive_d(4'hE, 0, 0, 0, 0, 1, 2'b11, 4'h0, 4'h0);
    step();
    ALUFlags = 4'b0000;
    drive_d(4'h0, 0, 1, 0, 0, 0, 2'b11, 4'h0, 4'h3);  // ADDEQ
    step();
    check("clr_flags", {28'h0, Flags}, 32'h0);
    check("addeq_condex", {31'h0, CondExE}, 32'h0);
    check("addeq_regw", {31'h0, RegWriteE}, 32'h0);
    ALUFlags = 4'b1001;
    idle_d();
    step();
`ifdef COND_ANNUL_CNT_EN
    exp_annul = 32'd1;
`endif
    check("addeq_flags", {28'h0, Flags}, 32'h0);
    check("addeq_annul", AnnulCount, exp_annul);

    // Partial write: NZCV=1111, then N,Z-only write of 0000 -> 0011
    drive_d(4'hE, 0, 0, 0, 0, 1, 2'b11, 4'h0, 4'h0);
    step();
    ALUFlags = 4'b1111;
    drive_d(4'hE, 0, 0, 0, 0, 1, 2'b10, 4'h0, 4'h0);
    step();
    check("set_all", {28'h0, Flags}, 32'hF);
    ALUFlags = 4'b0000;
    idle_d();
    step();
    check("partial", {28'h0, Flags}, 32'h3);

    // Stall a flag-setting instruction for three cycles
    drive_d(4'hE, 0, 1, 0, 0, 0, 2'b11, 4'h4, 4'h7);
    step();
    StallE = 1'b1;
    ALUFlags = 4'b1000;
    drive_d(4'hF, 1, 1, 1, 1, 0, 2'b11, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_flags", {28'h0, Flags}, 32'h3);
      check("stall_hold_wa3", {28'h0, WA3E}, 32'h7);
      check("stall_hold_regw", {31'h0, RegWriteE}, 32'h1);
    end
    StallE = 1'b0;
    idle_d();
    step();
    check("stall_release", {28'h0, Flags}, 32'h8);
    check("after_stall_regw", {31'h0, RegWriteE}, 32'h0);

    // Flush plus stall: bubble loads, flags held
    drive_d(4'hE, 1, 1, 1, 1, 0, 2'b11, 4'h9, 4'hA);
    step();
    check("pre_flush_memw", {31'h0, MemWriteE}, 32'h1);
    StallE = 1'b1; FlushE = 1'b1;
    ALUFlags = 4'b0111;
    step();
    check("flush_flags", {28'h0, Flags}, 32'h8);
    check("flush_aluctl", {28'h0, ALUControlE}, 32'h0);
    check("flush_wa3", {28'h0, WA3E}, 32'h0);
    check("flush_ctl", {26'h0, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, IgRnE}, 32'h0);
    check("flush_condex", {31'h0, CondExE}, 32'h0);
    StallE = 1'b0; FlushE = 1'b0;

    // Sweep every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive_d(4'hE, 0, 0, 0, 0, 1, 2'b11, 4'h0, 4'h0);
        step();
        ALUFlags = f[3:0];
        drive_d(c[3:0], 0, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0);
        step();
        check($sformatf("cond_%0h_flags_%0h", c, f), {31'h0, CondExE}, {31'h0, cond_ref(c[3:0], f[3:0])});
      end
    end

    // Asynchronous reset mid-run with a live instruction in E
    drive_d(4'hE, 1, 1, 0, 0, 0, 2'b00, 4'h1, 4'h2);
    step();
    check("prerst_regw", {31'h0, RegWriteE}, 32'h1);
    check("prerst_flags", {28'h0, Flags}, 32'hF);
    check("prerst_annul", AnnulCount, exp_annul);
    #2 reset = 1'b0;
    #1;
    check("arst_flags", {28'h0, Flags}, 32'h0);
    check("arst_regw", {31'h0, RegWriteE}, 32'h0);
    check("arst_pcsrc", {31'h0, PCSrcE}, 32'h0);
    check("arst_annul", AnnulCount, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
